multi_edge_debouncer: RTL and testbench

MULTI_EDGE_DEBOUNCER -- requirements
Module: multi_edge_debouncer

---
 rtl/multi_edge_debouncer_pkg.sv | 25 ++
 rtl/multi_edge_debouncer_debounce_channel.sv | 119 +++++++++++
 rtl/multi_edge_debouncer.sv | 44 ++++
 tb/tb_multi_edge_debouncer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_debouncer_pkg.sv
// Shared types and default timing for the multi-channel debouncer.
// Default constants assume a 100 MHz system clock.
package multi_edge_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int SYS_CLK_HZ                   = 100_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES      = SYS_CLK_HZ / 200;  // 5 ms
  localparam int DEFAULT_REPEAT_DELAY_CYCLES  = SYS_CLK_HZ / 2;    // 500 ms
  localparam int DEFAULT_REPEAT_PERIOD_CYCLES = SYS_CLK_HZ / 10;   // 100 ms

  // Repeat counter width; floored at 1 so a 1-cycle delay/period still has a counter bit.
  function automatic int rpt_cnt_width(input int delay_cycles, input int period_cycles);
    int longest;
    int w;
    longest = (delay_cycles > period_cycles) ? delay_cycles : period_cycles;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_edge_debouncer_debounce_channel.sv
// One debounced channel: two-flop synchroniser, debounce counter, auto-repeat FSM.
// Repeat FSM state is exported on rpt_state for observation.
module debounce_channel
  import multi_edge_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pin,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       rpt,
  output rpt_state_e rpt_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RC_W = rpt_cnt_width(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LOAD  = RC_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RC_W-1:0] PERIOD_LOAD = RC_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam bit              RPT_ON      = (REPEAT_EN != 0);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            rpt_q, rpt_d;
  logic [RC_W-1:0] rc_q, rc_d;
  rpt_state_e      state_q, state_d;

  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    db_cnt_d = '0;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    state_d  = state_q;
    rc_d     = rc_q;
    rpt_d    = 1'b0;

    // The counter holds mismatches seen so far; the DEBOUNCE_CYCLES-th one flips level.
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Keyed off the next level so a fall cycle can never also carry a repeat pulse.
    if (!level_d || !RPT_ON) begin
      state_d = IDLE;
      rc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_d) begin
            state_d = DELAY;
            rc_d    = DELAY_LOAD;
          end
        end
        DELAY, REPEAT: begin
          if (rc_q == '0) begin
            state_d = REPEAT;
            rpt_d   = 1'b1;
            rc_d    = PERIOD_LOAD;
          end else begin
            rc_d = rc_q - RC_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      rpt_q    <= 1'b0;
      rc_q     <= '0;
      state_q  <= IDLE;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rpt_q    <= rpt_d;
      rc_q     <= rc_d;
      state_q  <= state_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign rpt       = rpt_q;
  assign rpt_state = state_q;

endmodule

// File: rtl/multi_edge_debouncer.sv
// Multi-channel pin debouncer with edge pulses and optional auto-repeat.
// Each channel is independent; per-channel repeat state is packed into dbg_rpt_state.
module multi_edge_debouncer
  import multi_edge_debouncer_pkg::*;
#(
  parameter int CHANNELS             = 4,
  parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   pin,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   rpt,
  output logic [2*CHANNELS-1:0] dbg_rpt_state
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    rpt_state_e ch_state;

    debounce_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_EN            (REPEAT_EN),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin       (pin[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .rpt       (rpt[i]),
      .rpt_state (ch_state)
    );

    assign dbg_rpt_state[2*i +: 2] = ch_state;
  end

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Bench for multi_edge_debouncer: vector table, corner sequences, random stimulus vs a window-based model.
// Timing offsets are counted in clock edges from the first edge that samples a pin change.
module tb_multi_edge_debouncer;
  import multi_edge_debouncer_pkg::*;

  localparam int CH   = 4;
  localparam int DB   = 8;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int MAXE = 8192;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   pin;
  logic [CH-1:0]   level, rise, fall, rpt;
  logic [2*CH-1:0] dbg_rpt_state;

  int n_checks = 0;
  int n_fail   = 0;

  multi_edge_debouncer #(
    .CHANNELS             (CH),
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_EN            (1),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin           (pin),
    .level         (level),
    .rise          (rise),
    .fall          (fall),
    .rpt           (rpt),
    .dbg_rpt_state (dbg_rpt_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Level flips once the last DB samples seen by the debounce logic all disagree with it
  // and no flip happened inside that window. Repeats fall on rise+RD+m*RP while level holds.
  logic [CH-1:0] pin_at [MAXE];
  int            m_n;
  logic [CH-1:0] m_level, m_rise, m_fall, m_rpt;
  int            m_last_flip [CH];
  int            m_rise_edge [CH];

  function automatic logic m_sync(input int e, input int c);
    if (e - 2 < 1) return 1'b0;
    return pin_at[e-2][c];
  endfunction

  task automatic model_reset();
    m_n     = 0;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_rpt   = '0;
    for (int c = 0; c < CH; c++) begin
      m_last_flip[c] = 0;
      m_rise_edge[c] = 0;
    end
  endtask

  task automatic model_step();
    bit stable;
    int age;
    m_n++;
    if (m_n >= MAXE) begin
      n_fail++;
      $display("FAIL model_capacity: edge=%0d limit=%0d", m_n, MAXE);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "model history exhausted");
    end
    pin_at[m_n] = pin;
    m_rise = '0;
    m_fall = '0;
    m_rpt  = '0;
    for (int c = 0; c < CH; c++) begin
      stable = (m_n - m_last_flip[c] >= DB);
      for (int j = 0; j < DB; j++)
        if (m_sync(m_n - j, c) == m_level[c]) stable = 1'b0;
      if (stable) begin
        m_level[c]     = ~m_level[c];
        m_last_flip[c] = m_n;
        if (m_level[c]) begin
          m_rise[c]      = 1'b1;
          m_rise_edge[c] = m_n;
        end else begin
          m_fall[c] = 1'b1;
        end
      end
      age = m_n - m_rise_edge[c];
      if (m_level[c] && age >= RD && ((age - RD) % RP) == 0) m_rpt[c] = 1'b1;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("model_level", level, m_level);
    check("model_rise",  rise,  m_rise);
    check("model_fall",  fall,  m_fall);
    check("model_rpt",   rpt,   m_rpt);
  endtask

  task automatic settle(input int n);
    pin = '0;
    repeat (n) tick();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("async_reset_level", level, 0);
    check("async_reset_rise",  rise,  0);
    check("async_reset_fall",  fall,  0);
    check("async_reset_rpt",   rpt,   0);
    model_reset();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int ch;
    int width;
    int exp_rises;
    int exp_rise_off;
    int exp_falls;
    int exp_fall_off;
    int exp_rpts;
  } vec_t;

  vec_t          vecs [8];
  vec_t          v;
  int            rises, falls, rpts, rise_off, fall_off, others;
  logic [CH-1:0] other_mask;
  logic [2*CH-1:0] exp_dbg;
  int            hold [CH];
  int            rise_cnt;

  initial begin
    // pulse width on one pin -> rise count/offset, fall count/offset (from release), repeat count
    vecs[0] = '{0,  1, 0, -1, 0, -1, 0};
    vecs[1] = '{1,  7, 0, -1, 0, -1, 0};
    vecs[2] = '{1,  8, 1,  9, 1,  9, 0};
    vecs[3] = '{2, 20, 1,  9, 1,  9, 0};
    vecs[4] = '{3, 21, 1,  9, 1,  9, 1};
    vecs[5] = '{0, 25, 1,  9, 1,  9, 1};
    vecs[6] = '{1, 26, 1,  9, 1,  9, 2};
    vecs[7] = '{2, 40, 1,  9, 1,  9, 4};

    pin   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    for (int c = 0; c < CH; c++) exp_dbg[2*c +: 2] = IDLE;
    check("reset_rpt_state", dbg_rpt_state, exp_dbg);
    rst_n = 1'b1;
    settle(12);

    for (int t = 0; t < 8; t++) begin
      v = vecs[t];
      settle(4);
      rises = 0; falls = 0; rpts = 0; rise_off = -1; fall_off = -1; others = 0;
      other_mask = ~(CH'(1) << v.ch);
      for (int e = 0; e < v.width + 45; e++) begin
        pin = '0;
        pin[v.ch] = (e < v.width);
        tick();
        if (rise[v.ch]) begin rises++; if (rise_off < 0) rise_off = e; end
        if (fall[v.ch]) begin falls++; if (fall_off < 0) fall_off = e - v.width; end
        if (rpt[v.ch]) rpts++;
        others += $countones((rise | fall | rpt) & other_mask);
      end
      check("vec_rises",    rises,    v.exp_rises);
      check("vec_rise_off", rise_off, v.exp_rise_off);
      check("vec_falls",    falls,    v.exp_falls);
      check("vec_fall_off", fall_off, v.exp_fall_off);
      check("vec_rpts",     rpts,     v.exp_rpts);
      check("vec_others",   others,   0);
      check("vec_level_end", level[v.ch], 0);
    end

    // reset 4 edges into a debounce, pin kept high through release
    pin = '0;
    pin[0] = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    apply_reset(4);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("rst_release_rise0", rise[0], (i == 10));
      check("rst_release_others", rise[3:1], 0);
    end
    settle(20);

    // all four pins rise on the same edge
    pin = 4'hF;
    for (int e = 0; e < 15; e++) begin
      tick();
      check("all_rise", rise, (e == 9) ? 15 : 0);
    end
    settle(20);

    // held 60 edges: repeats at rise+20, +25, ...; none on or after the fall
    for (int e = 0; e < 85; e++) begin
      pin = '0;
      pin[3] = (e < 60);
      tick();
      check("hold_rise3", rise[3], (e == 9));
      check("hold_rpt3",  rpt[3],  (e >= 29 && e < 69 && ((e - 29) % 5) == 0));
      check("hold_fall3", fall[3], (e == 69));
    end
    settle(5);

    // bounce every 3 edges for 30 edges, then steady high
    rise_cnt = 0;
    for (int e = 0; e < 56; e++) begin
      pin = '0;
      pin[2] = (e < 30) ? (((e / 3) % 2) == 0) : 1'b1;
      tick();
      if (rise[2]) rise_cnt++;
      check("bounce_rise2", rise[2], (e == 39));
    end
    check("bounce_rise_count", rise_cnt, 1);
    settle(25);

    // random holds per channel, one mid-run reset
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 60);
    for (int e = 0; e < 2500; e++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          pin[c]  = ~pin[c];
          hold[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(13, 60);
        end else begin
          hold[c]--;
        end
      end
      if (e == 1300) apply_reset(3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
